// File: rtl/morse_sequencer.sv
// Morse letter sequencer for letters A-H: latches a letter on start, then drives
// the LED with timed marks/gaps from an internal unit divider and pulses done at the end.
module morse_sequencer #(
  parameter int TICK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] letter,
  output logic       led,
  output logic       busy,
  output logic       ready,
  output logic       done
);

  localparam int CW = $clog2(3 * TICK_DIV + 1);
  localparam logic [CW-1:0] UNIT = CW'(TICK_DIV);
  localparam logic [CW-1:0] LONG = CW'(3 * TICK_DIV);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = CW'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    GAP  = 2'd2,
    TAIL = 2'd3
  } state_t;

  // Pattern is MSB first (1 = dash); unused trailing bits are zero.
  function automatic logic [6:0] rom_lookup(input logic [2:0] code);
    logic [6:0] entry;
    case (code)
      3'd0:    entry = {4'b0100, 3'd2};
      3'd1:    entry = {4'b1000, 3'd4};
      3'd2:    entry = {4'b1010, 3'd4};
      3'd3:    entry = {4'b1000, 3'd3};
      3'd4:    entry = {4'b0000, 3'd1};
      3'd5:    entry = {4'b0010, 3'd4};
      3'd6:    entry = {4'b1100, 3'd3};
      3'd7:    entry = {4'b0000, 3'd4};
      default: entry = {4'b0000, 3'd1};
    endcase
    return entry;
  endfunction

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [3:0]      pat_r, pat_s;
  logic [2:0]      len_r, len_s;
  logic [1:0]      idx_r, idx_s;
  logic            done_s;
  logic [6:0]      rom_s;
  logic            led_r, busy_r, ready_r, done_r;

  assign rom_s = rom_lookup(letter);

  // Next-state, counter and element bookkeeping; pat_r shifts so bit 3 is always the current element.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    pat_s   = pat_r;
    len_s   = len_r;
    idx_s   = idx_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          pat_s   = rom_s[6:3];
          len_s   = rom_s[2:0];
          idx_s   = 2'd0;
          cnt_s   = rom_s[6] ? LONG : UNIT;
          state_s = MARK;
        end else begin
          state_s = IDLE;
        end
      end
      MARK: begin
        if (cnt_r == ONE) begin
          if (({1'b0, idx_r} + 3'd1) < len_r) begin
            state_s = GAP;
            cnt_s   = UNIT;
          end else begin
            state_s = TAIL;
            cnt_s   = LONG;
          end
        end else begin
          cnt_s = cnt_r - ONE;
        end
      end
      GAP: begin
        if (cnt_r == ONE) begin
          state_s = MARK;
          idx_s   = idx_r + 2'd1;
          pat_s   = {pat_r[2:0], 1'b0};
          cnt_s   = pat_r[2] ? LONG : UNIT;
        end else begin
          cnt_s = cnt_r - ONE;
        end
      end
      TAIL: begin
        if (cnt_r == ONE) begin
          state_s = IDLE;
          cnt_s   = ZERO;
          done_s  = 1'b1;
        end else begin
          cnt_s = cnt_r - ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = ZERO;
      end
    endcase
  end

  // State and registered outputs, derived from the next state so they align with it.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_r <= IDLE;
      cnt_r   <= ZERO;
      pat_r   <= 4'b0000;
      len_r   <= 3'd0;
      idx_r   <= 2'd0;
      led_r   <= 1'b0;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pat_r   <= pat_s;
      len_r   <= len_s;
      idx_r   <= idx_s;
      led_r   <= (state_s == MARK);
      busy_r  <= (state_s != IDLE);
      ready_r <= (state_s == IDLE);
      done_r  <= done_s;
    end
  end

  assign led   = led_r;
  assign busy  = busy_r;
  assign ready = ready_r;
  assign done  = done_r;

endmodule

// File: tb/tb_morse_sequencer.sv
// Scoreboard bench for morse_sequencer: expected {led,busy,ready,done} per cycle is
// queued when a letter is launched and popped/compared every cycle on the falling edge.
module tb_morse_sequencer;

  localparam int T = 4;
  localparam logic [3:0] IDLE_V = 4'b0010;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [2:0] letter;
  logic       led, busy, ready, done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [3:0] exp_q[$];
  string codes [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

  morse_sequencer #(.TICK_DIV(T)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .letter (letter),
    .led    (led),
    .busy   (busy),
    .ready  (ready),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp_v);
    checks++;
    assert (got === exp_v)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d got(led,busy,ready,done)=%b exp=%b", tag, cyc, got, exp_v);
    end
  endtask

  // Advance one cycle and compare against the next queued expectation (idle if none queued).
  task automatic tick(input string tag);
    logic [3:0] exp_v;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
    check(tag, {led, busy, ready, done}, exp_v);
  endtask

  // Queue the expected waveform of one letter, starting the cycle after acceptance.
  task automatic push_letter(input int l);
    string c;
    int n;
    c = codes[l];
    for (int i = 0; i < c.len(); i++) begin
      n = (c[i] == 8'h2D) ? 3 : 1;
      repeat (n * T) exp_q.push_back(4'b1100);
      if (i < c.len() - 1) repeat (T) exp_q.push_back(4'b0100);
    end
    repeat (3 * T) exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0011);
  endtask

  task automatic run_letter(input int l, input string tag);
    int n;
    letter = l[2:0];
    start  = 1'b1;
    push_letter(l);
    tick(tag);
    start = 1'b0;
    n = exp_q.size();
    repeat (n) tick(tag);
    repeat (2) tick({tag, "_idle"});
  endtask

  initial begin
    int n;
    resetn = 1'b1;
    start  = 1'b0;
    letter = 3'd0;
    repeat (3) tick("reset");
    resetn = 1'b0;
    repeat (2) tick("post_reset");

    run_letter(4, "E");
    run_letter(0, "A");

    // H with a second start mid-letter that must be ignored
    letter = 3'd7;
    start  = 1'b1;
    push_letter(7);
    tick("H");
    start = 1'b0;
    repeat (9) tick("H");
    start = 1'b1;
    tick("H");
    start = 1'b0;
    n = exp_q.size();
    repeat (n) tick("H");
    repeat (2) tick("H_idle");

    // C with the letter input changed after acceptance
    letter = 3'd2;
    start  = 1'b1;
    push_letter(2);
    tick("C");
    start = 1'b0;
    repeat (2) tick("C");
    letter = 3'd4;
    n = exp_q.size();
    repeat (n) tick("C");
    repeat (2) tick("C_idle");

    // B aborted by reset partway through its first dash
    letter = 3'd1;
    start  = 1'b1;
    push_letter(1);
    tick("B");
    start = 1'b0;
    repeat (4) tick("B");
    exp_q.delete();
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    cyc++;
    check("B_reset", {led, busy, ready, done}, IDLE_V);
    tick("B_reset");
    resetn = 1'b0;
    repeat (4) tick("B_after");
    run_letter(4, "E_after_reset");

    run_letter(3, "D");
    run_letter(5, "F");
    run_letter(6, "G");

    // start held high: E repeats back to back
    letter = 3'd4;
    start  = 1'b1;
    push_letter(4);
    for (int k = 0; k < 3; k++) begin
      repeat (17) tick("E_hold");
      if (k < 2) push_letter(4);
      else start = 1'b0;
    end
    repeat (3) tick("E_hold_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
